exe_mem_req_unit: RTL and testbench

Parametrised data-side memory request unit that sits between the EXE-stage datapath and the data SRAM-like bus. It latches one load/store, translates its address (direct, N direct-map windows, or TLB), checks alignment and TLB permission exceptions, and issues it with req/addr_ok. Up to OST_DEPTH accepted requests can be outstanding on data_ok; they are tracked in order, and responses from flushed requests are discarded.

---
 rtl/exe_mem_req_unit.sv | 160 ++++++++++++++++
 tb/tb_exe_mem_req_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_mem_req_unit.sv
// exe_mem_req_unit: latches one EXE-stage load/store, translates and checks it, issues it on the
// data bus and tracks up to OST_DEPTH accepted requests in order until their data_ok.
module exe_mem_req_unit #(
    parameter int DMW_NUM   = 2,
    parameter int OST_DEPTH = 4,
    parameter int INFO_W    = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_wr,
    input  logic [1:0]                    req_size,
    input  logic [31:0]                   req_vaddr,
    input  logic [31:0]                   req_wdata,
    input  logic [INFO_W-1:0]             req_info,
    input  logic                          flush,
    input  logic                          dat_mode,
    input  logic [1:0]                    crmd_plv,
    input  logic [9:0]                    csr_asid,
    input  logic [3*DMW_NUM-1:0]          dmw_vseg,
    input  logic [3*DMW_NUM-1:0]          dmw_pseg,
    input  logic [DMW_NUM-1:0]            dmw_plv0,
    input  logic [DMW_NUM-1:0]            dmw_plv3,
    output logic [18:0]                   tlb_vppn,
    output logic                          tlb_va_bit12,
    output logic [9:0]                    tlb_asid,
    input  logic                          tlb_found,
    input  logic                          tlb_v,
    input  logic                          tlb_d,
    input  logic [19:0]                   tlb_ppn,
    input  logic [5:0]                    tlb_ps,
    input  logic [1:0]                    tlb_plv,
    output logic                          ex_valid,
    output logic [5:0]                    ex_code,
    output logic [31:0]                   ex_vaddr,
    output logic [INFO_W-1:0]             ex_info,
    output logic                          data_sram_req,
    output logic                          data_sram_wr,
    output logic [1:0]                    data_sram_size,
    output logic [3:0]                    data_sram_wstrb,
    output logic [31:0]                   data_sram_addr,
    output logic [31:0]                   data_sram_wdata,
    input  logic                          data_sram_addr_ok,
    input  logic                          data_sram_data_ok,
    input  logic [31:0]                   data_sram_rdata,
    output logic                          rsp_valid,
    output logic [31:0]                   rsp_rdata,
    output logic [INFO_W-1:0]             rsp_info,
    output logic                          rsp_wr,
    output logic [$clog2(OST_DEPTH):0]    ost_cnt
);
    localparam int PW = $clog2(OST_DEPTH);
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t               state;
    logic                 r_wr;
    logic [1:0]           r_size;
    logic [31:0]          r_vaddr, r_wdata;
    logic [INFO_W-1:0]    r_info;
    logic [INFO_W-1:0]    q_info [OST_DEPTH];
    logic [OST_DEPTH-1:0] q_wr, q_disc;
    logic [PW-1:0]        head, tail;
    logic                 is_issue, ale, dmw_hit, tlb_mode, exc, push, pop, done;
    logic [2:0]           dmw_seg;
    logic [5:0]           code;
    logic [31:0]          pa, wd;
    logic [3:0]           strb;

    // Lowest-numbered matching window wins, so scan from the top down.
    always_comb begin
        dmw_hit = 1'b0;
        dmw_seg = 3'd0;
        for (int i = DMW_NUM - 1; i >= 0; i--)
            if (r_vaddr[31:29] == dmw_vseg[3*i +: 3] &&
                ((crmd_plv == 2'd0 && dmw_plv0[i]) || (crmd_plv == 2'd3 && dmw_plv3[i]))) begin
                dmw_hit = 1'b1;
                dmw_seg = dmw_pseg[3*i +: 3];
            end
    end

    assign is_issue = state == ISSUE;
    assign tlb_mode = ~dat_mode & ~dmw_hit;
    assign ale      = (r_size == 2'd2 && r_vaddr[1:0] != 2'd0) || (r_size == 2'd1 && r_vaddr[0]);
    assign pa       = dat_mode ? r_vaddr :
                      dmw_hit ? {dmw_seg, r_vaddr[28:0]} :
                      tlb_ps == 6'd21 ? {tlb_ppn[19:9], r_vaddr[20:0]} : {tlb_ppn, r_vaddr[11:0]};
    // Alignment fault masks every TLB fault; the TLB faults are mutually exclusive.
    assign code     = ale ? 6'b100000 :
                      tlb_mode ? {1'b0, ~tlb_found,
                                  ~r_wr & tlb_found & ~tlb_v,
                                  r_wr & tlb_found & ~tlb_v,
                                  r_wr & tlb_found & tlb_v & (crmd_plv <= tlb_plv) & ~tlb_d,
                                  tlb_found & tlb_v & (crmd_plv > tlb_plv)} : 6'd0;
    assign strb     = r_size == 2'd0 ? 4'b0001 << r_vaddr[1:0] :
                      r_size == 2'd1 ? 4'b0011 << {r_vaddr[1], 1'b0} : 4'hF;
    assign wd       = r_size == 2'd0 ? {4{r_wdata[7:0]}} :
                      r_size == 2'd1 ? {2{r_wdata[15:0]}} : r_wdata;

    assign exc       = is_issue & |code;
    assign ex_valid  = exc & ~flush;
    assign ex_code   = is_issue ? code : 6'd0;
    assign ex_vaddr  = r_vaddr;
    assign ex_info   = r_info;
    assign data_sram_req   = is_issue & ~exc & ~ost_cnt[PW] & ~flush;
    assign data_sram_wr    = is_issue & r_wr;
    assign data_sram_size  = is_issue ? r_size : 2'd0;
    assign data_sram_addr  = is_issue ? pa : 32'd0;
    assign data_sram_wstrb = is_issue && r_wr ? strb : 4'd0;
    assign data_sram_wdata = is_issue ? wd : 32'd0;
    assign tlb_vppn     = r_vaddr[31:13];
    assign tlb_va_bit12 = r_vaddr[12];
    assign tlb_asid     = csr_asid;

    assign push      = data_sram_req & data_sram_addr_ok;
    assign done      = ex_valid | push;
    assign req_ready = ~flush & (~is_issue | done);
    assign pop       = data_sram_data_ok & |ost_cnt;
    assign rsp_valid = pop & ~q_disc[head] & ~flush;
    assign rsp_rdata = data_sram_rdata;
    assign rsp_info  = q_info[head];
    assign rsp_wr    = q_wr[head];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_vaddr <= 32'd0;
            r_wdata <= 32'd0;
            r_info  <= '0;
            head    <= '0;
            tail    <= '0;
            ost_cnt <= '0;
            q_wr    <= '0;
            q_disc  <= '0;
            for (int i = 0; i < OST_DEPTH; i++) q_info[i] <= '0;
        end else begin
            if (req_valid && req_ready) begin
                state   <= ISSUE;
                r_wr    <= req_wr;
                r_size  <= req_size;
                r_vaddr <= req_vaddr;
                r_wdata <= req_wdata;
                r_info  <= req_info;
            end else if (flush || done) begin
                state <= IDLE;
            end
            if (push) begin
                q_info[tail] <= r_info;
                q_wr[tail]   <= r_wr;
                q_disc[tail] <= 1'b0;
                tail         <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            // Push never coincides with flush, so marking every slot is safe.
            if (flush) q_disc <= '1;
            ost_cnt <= ost_cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end
endmodule

// File: tb/tb_exe_mem_req_unit.sv
// tb_exe_mem_req_unit: directed vector table plus hand-written sequences for exe_mem_req_unit.
module tb_exe_mem_req_unit;
    logic        clk = 1'b0, resetn = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_wr = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_vaddr = 32'd0, req_wdata = 32'd0;
    logic [7:0]  req_info = 8'd0;
    logic        flush = 1'b0, dat_mode = 1'b0;
    logic [1:0]  crmd_plv = 2'd0;
    logic [9:0]  csr_asid = 10'h155;
    logic [5:0]  dmw_vseg = 6'b100_000, dmw_pseg = 6'b001_101;
    logic [1:0]  dmw_plv0 = 2'b01, dmw_plv3 = 2'b10;
    logic [18:0] tlb_vppn;
    logic        tlb_va_bit12;
    logic [9:0]  tlb_asid;
    logic        tlb_found = 1'b0, tlb_v = 1'b0, tlb_d = 1'b0;
    logic [19:0] tlb_ppn = 20'd0;
    logic [5:0]  tlb_ps = 6'd12;
    logic [1:0]  tlb_plv = 2'd0;
    logic        ex_valid;
    logic [5:0]  ex_code;
    logic [31:0] ex_vaddr;
    logic [7:0]  ex_info;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        addr_ok = 1'b0, data_ok = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic        rsp_valid, rsp_wr;
    logic [31:0] rsp_rdata;
    logic [7:0]  rsp_info;
    logic [2:0]  ost_cnt;

    exe_mem_req_unit dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_size(req_size), .req_vaddr(req_vaddr), .req_wdata(req_wdata),
        .req_info(req_info), .flush(flush), .dat_mode(dat_mode), .crmd_plv(crmd_plv),
        .csr_asid(csr_asid), .dmw_vseg(dmw_vseg), .dmw_pseg(dmw_pseg), .dmw_plv0(dmw_plv0),
        .dmw_plv3(dmw_plv3), .tlb_vppn(tlb_vppn), .tlb_va_bit12(tlb_va_bit12), .tlb_asid(tlb_asid),
        .tlb_found(tlb_found), .tlb_v(tlb_v), .tlb_d(tlb_d), .tlb_ppn(tlb_ppn), .tlb_ps(tlb_ps),
        .tlb_plv(tlb_plv), .ex_valid(ex_valid), .ex_code(ex_code), .ex_vaddr(ex_vaddr),
        .ex_info(ex_info), .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(addr_ok), .data_sram_data_ok(data_ok), .data_sram_rdata(rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_info(rsp_info), .rsp_wr(rsp_wr),
        .ost_cnt(ost_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] va, wd;
        logic        dm;
        logic [1:0]  plv;
        logic        f, v, d;
        logic [19:0] ppn;
        logic [5:0]  ps;
        logic [1:0]  tplv;
        logic        ereq;
        logic [31:0] eaddr;
        logic [3:0]  estrb;
        logic [31:0] ewdata;
        logic [5:0]  ecode;
    } vec_t;

    vec_t vt [16];
    int   n_vec = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq, expi;
        logic acc;
        // wr size va wd dm plv f v d ppn ps tplv | req addr strb wdata code
        vt[0]  = '{0, 2, 32'h1C000100, 32'h0, 1, 0, 0, 0, 0, 20'h0, 12, 0, 1, 32'h1C000100, 4'h0, 32'h0, 6'b000000};
        vt[1]  = '{1, 0, 32'h00000003, 32'hA5, 0, 0, 0, 0, 0, 20'h0, 12, 0, 1, 32'hA0000003, 4'h8, 32'hA5A5A5A5, 6'b000000};
        vt[2]  = '{1, 1, 32'h00400002, 32'hBEEF, 0, 3, 1, 1, 0, 20'hABCDE, 12, 3, 0, 32'h0, 4'h0, 32'h0, 6'b000010};
        vt[3]  = '{1, 1, 32'h00400001, 32'hBEEF, 0, 3, 1, 1, 0, 20'hABCDE, 12, 3, 0, 32'h0, 4'h0, 32'h0, 6'b100000};
        vt[4]  = '{0, 2, 32'h12345678, 32'h0, 0, 3, 1, 1, 1, 20'hABCDE, 12, 3, 1, 32'hABCDE678, 4'h0, 32'h0, 6'b000000};
        vt[5]  = '{1, 2, 32'h12345678, 32'h11223344, 0, 3, 1, 1, 1, 20'hABCDE, 21, 3, 1, 32'hABD45678, 4'hF, 32'h11223344, 6'b000000};
        vt[6]  = '{0, 2, 32'h00001000, 32'h0, 0, 3, 0, 0, 0, 20'h0, 12, 0, 0, 32'h0, 4'h0, 32'h0, 6'b010000};
        vt[7]  = '{0, 2, 32'h00001000, 32'h0, 0, 3, 1, 0, 0, 20'hABCDE, 12, 3, 0, 32'h0, 4'h0, 32'h0, 6'b001000};
        vt[8]  = '{1, 2, 32'h00001000, 32'h0, 0, 3, 1, 0, 0, 20'hABCDE, 12, 3, 0, 32'h0, 4'h0, 32'h0, 6'b000100};
        vt[9]  = '{0, 2, 32'h00001000, 32'h0, 0, 3, 1, 1, 1, 20'hABCDE, 12, 0, 0, 32'h0, 4'h0, 32'h0, 6'b000001};
        vt[10] = '{0, 2, 32'h80000010, 32'h0, 0, 3, 0, 0, 0, 20'h0, 12, 0, 1, 32'h20000010, 4'h0, 32'h0, 6'b000000};
        vt[11] = '{1, 1, 32'h00000002, 32'hBEEF, 1, 0, 0, 0, 0, 20'h0, 12, 0, 1, 32'h00000002, 4'hC, 32'hBEEFBEEF, 6'b000000};
        vt[12] = '{1, 2, 32'h1C000102, 32'h0, 1, 0, 0, 0, 0, 20'h0, 12, 0, 0, 32'h0, 4'h0, 32'h0, 6'b100000};
        vt[13] = '{0, 2, 32'h00400003, 32'h0, 0, 3, 0, 0, 0, 20'h0, 12, 0, 0, 32'h0, 4'h0, 32'h0, 6'b100000};
        vt[14] = '{1, 0, 32'h1C000001, 32'h12345677, 1, 0, 0, 0, 0, 20'h0, 12, 0, 1, 32'h1C000001, 4'h2, 32'h77777777, 6'b000000};
        vt[15] = '{1, 2, 32'h40000000, 32'h0, 0, 0, 1, 1, 0, 20'hABCDE, 12, 3, 0, 32'h0, 4'h0, 32'h0, 6'b000010};

        tick();
        tick();
        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset req", 32'(data_sram_req), 32'd0);
        chk("reset ex_valid", 32'(ex_valid), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset ost_cnt", 32'(ost_cnt), 32'd0);
        chk("reset addr", data_sram_addr, 32'd0);
        resetn = 1'b1;
        tick();

        addr_ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            req_wr = vt[k].wr; req_size = vt[k].size; req_vaddr = vt[k].va; req_wdata = vt[k].wd;
            req_info = 8'(k); dat_mode = vt[k].dm; crmd_plv = vt[k].plv;
            tlb_found = vt[k].f; tlb_v = vt[k].v; tlb_d = vt[k].d;
            tlb_ppn = vt[k].ppn; tlb_ps = vt[k].ps; tlb_plv = vt[k].tplv;
            req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d req", k), 32'(data_sram_req), 32'(vt[k].ereq));
            chk($sformatf("v%0d ex_valid", k), 32'(ex_valid), 32'(|vt[k].ecode));
            chk($sformatf("v%0d ex_code", k), 32'(ex_code), 32'(vt[k].ecode));
            chk($sformatf("v%0d tlb_vppn", k), 32'(tlb_vppn), 32'(vt[k].va[31:13]));
            if (vt[k].ereq) begin
                chk($sformatf("v%0d addr", k), data_sram_addr, vt[k].eaddr);
                chk($sformatf("v%0d wstrb", k), 32'(data_sram_wstrb), 32'(vt[k].estrb));
                chk($sformatf("v%0d wdata", k), data_sram_wdata, vt[k].ewdata);
                chk($sformatf("v%0d wr", k), 32'(data_sram_wr), 32'(vt[k].wr));
                tick();
                data_ok = 1'b1;
                rdata = 32'hC0DE0000 + 32'(k);
                @(negedge clk);
                chk($sformatf("v%0d ost_cnt", k), 32'(ost_cnt), 32'd1);
                chk($sformatf("v%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
                chk($sformatf("v%0d rsp_rdata", k), rsp_rdata, 32'hC0DE0000 + 32'(k));
                chk($sformatf("v%0d rsp_info", k), 32'(rsp_info), 32'(k));
                chk($sformatf("v%0d rsp_wr", k), 32'(rsp_wr), 32'(vt[k].wr));
                tick();
                data_ok = 1'b0;
            end else begin
                chk($sformatf("v%0d ex_vaddr", k), ex_vaddr, vt[k].va);
                chk($sformatf("v%0d ex_info", k), 32'(ex_info), 32'(k));
                tick();
                @(negedge clk);
                chk($sformatf("v%0d ex_valid one cycle", k), 32'(ex_valid), 32'd0);
                tick();
            end
        end

        // Tracker fills at four, then a pop only unblocks the following cycle.
        dat_mode = 1'b1; req_wr = 1'b0; req_size = 2'd2; req_vaddr = 32'h1C000200;
        req_info = 8'd0; req_valid = 1'b1; nreq = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            nreq += int'(data_sram_req);
            tick();
            if (acc) req_info++;
        end
        data_ok = 1'b1;
        @(negedge clk);
        chk("full issued", 32'(nreq), 32'd4);
        chk("full ost_cnt", 32'(ost_cnt), 32'd4);
        chk("full req held", 32'(data_sram_req), 32'd0);
        chk("full ready", 32'(req_ready), 32'd0);
        chk("full rsp_valid", 32'(rsp_valid), 32'd1);
        chk("full rsp_info", 32'(rsp_info), 32'd0);
        tick();
        data_ok = 1'b0;
        @(negedge clk);
        chk("unblock req", 32'(data_sram_req), 32'd1);
        chk("unblock ost_cnt", 32'(ost_cnt), 32'd3);
        tick();
        req_valid = 1'b0;
        data_ok = 1'b1;
        expi = 1;
        for (int c = 0; c < 20 && expi < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                chk($sformatf("drain info %0d", expi), 32'(rsp_info), 32'(expi));
                expi++;
            end
            tick();
        end
        data_ok = 1'b0;
        chk("drain count", 32'(expi), 32'd6);
        @(negedge clk);
        chk("drain ost_cnt", 32'(ost_cnt), 32'd0);
        tick();
        data_ok = 1'b1;
        @(negedge clk);
        chk("empty data_ok rsp", 32'(rsp_valid), 32'd0);
        tick();
        data_ok = 1'b0;
        @(negedge clk);
        chk("empty data_ok ost", 32'(ost_cnt), 32'd0);
        tick();

        // Flush with a same-cycle pop discards all three outstanding responses.
        req_info = 8'h10; req_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            req_info++;
        end
        req_valid = 1'b0;
        tick();
        flush = 1'b1;
        data_ok = 1'b1;
        @(negedge clk);
        chk("flush ost_cnt", 32'(ost_cnt), 32'd3);
        chk("flush rsp_valid", 32'(rsp_valid), 32'd0);
        chk("flush ready", 32'(req_ready), 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("post flush rsp 1", 32'(rsp_valid), 32'd0);
        chk("post flush ost 2", 32'(ost_cnt), 32'd2);
        tick();
        @(negedge clk);
        chk("post flush rsp 2", 32'(rsp_valid), 32'd0);
        chk("post flush ost 1", 32'(ost_cnt), 32'd1);
        tick();
        data_ok = 1'b0;
        @(negedge clk);
        chk("post flush ost 0", 32'(ost_cnt), 32'd0);
        tick();

        // Flush drops a request waiting for addr_ok.
        addr_ok = 1'b0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("wait req", 32'(data_sram_req), 32'd1);
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("flush kills req", 32'(data_sram_req), 32'd0);
        tick();
        flush = 1'b0;
        addr_ok = 1'b1;
        @(negedge clk);
        chk("dropped req", 32'(data_sram_req), 32'd0);
        chk("dropped ready", 32'(req_ready), 32'd1);
        tick();

        // Reset while a request stalls on addr_ok with one entry outstanding.
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        addr_ok = 1'b0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("stall req %0d", c), 32'(data_sram_req), 32'd1);
            chk($sformatf("stall addr %0d", c), data_sram_addr, 32'h1C000200);
            chk($sformatf("stall ost %0d", c), 32'(ost_cnt), 32'd1);
            tick();
        end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("rst req", 32'(data_sram_req), 32'd0);
        chk("rst ost_cnt", 32'(ost_cnt), 32'd0);
        chk("rst ready", 32'(req_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
